// File: rtl/reg_alu_seq.sv
// reg_alu_seq: 8-slot program sequencer that drives a register-file/ALU bus and captures selected results.
// Optional feature: define REG_ALU_SEQ_LOOP_EN to let a run wrap from slot len back to slot 0 while loop=1.
module reg_alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [28:0] ld_data,
    input  logic        start,
    input  logic [2:0]  len,
    input  logic        abort,
    input  logic        loop,
    output logic        sel,
    output logic        wr,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_in,
    input  logic [15:0] d_out_a,
    input  logic [15:0] d_out_b,
    input  logic        cout,
    output logic        busy,
    output logic        done,
    output logic [15:0] res,
    output logic        res_cout,
    output logic [3:0]  op_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t      state;
    logic [28:0] mem [8];
    logic [28:0] bus;
    logic [2:0]  ptr, last, nxt;
    logic        wrap;
    logic        unused_in;

    assign {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in} = bus;
    assign nxt = (ptr == last) ? 3'd0 : ptr + 3'd1;

`ifdef REG_ALU_SEQ_LOOP_EN
    assign wrap      = loop;
    assign unused_in = ^d_out_b;
`else
    assign wrap      = 1'b0;
    assign unused_in = ^{d_out_b, loop};
`endif

    // program memory: writable only while idle so a running program never changes under the bus
    always_ff @(posedge clk or negedge reset)
        if (!reset) mem <= '{default: '0};
        else if (ld_en && state == IDLE) mem[ld_addr] <= ld_data;

    // sequencer: issues one word per cycle, zero bus outside a run, captures ALU result on sel words
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            last     <= '0;
            bus      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            res      <= '0;
            res_cout <= 1'b0;
            op_cnt   <= '0;
        end else begin
            if (state == RUN && bus[28]) begin
                res      <= d_out_a;
                res_cout <= cout;
                op_cnt   <= op_cnt + 4'd1;
            end
            case (state)
                IDLE: if (start && !abort) begin
                    state <= RUN;
                    ptr   <= '0;
                    last  <= len;
                    bus   <= mem[0];
                    busy  <= 1'b1;
                end
                RUN: if (abort || (ptr == last && !wrap)) begin
                    state <= FIN;
                    bus   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    ptr <= nxt;
                    bus <= mem[nxt];
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: directed checks of program load, run, capture, abort, busy guards, loop and async reset.
module tb_reg_alu_seq;
    logic        clk = 1'b0, reset = 1'b0, ld_en = 1'b0, start = 1'b0, abort = 1'b0, loop = 1'b0;
    logic [2:0]  ld_addr = '0, len = '0;
    logic [28:0] ld_data = '0;
    logic        sel, wr, cout, busy, done, res_cout;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] d_in, d_out_a, d_out_b, res;
    logic [3:0]  op_cnt;
    logic [15:0] ret_a = '0;
    logic        ret_c = 1'b0;
    logic [28:0] bus;
    int          checks = 0, errors = 0, done_seen;

    reg_alu_seq dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .len(len), .abort(abort), .loop(loop),
        .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .wr_addr(wr_addr), .d_in(d_in), .d_out_a(d_out_a), .d_out_b(d_out_b), .cout(cout),
        .busy(busy), .done(done), .res(res), .res_cout(res_cout), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // ALU stand-in: returns the chosen value only while a sel word is on the bus
    assign d_out_a = sel ? ret_a : 16'hffff;
    assign cout    = sel ? ret_c : ~ret_c;
    assign d_out_b = 16'h5a5a;
    assign bus     = {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in};

    function automatic logic [28:0] pw(input int i);
        logic [2:0] k;
        k = 3'(i);
        return (i == 5) ? {1'b1, 1'b1, 2'b00, 3'd1, 3'd5, 3'd5, 16'h1005}
                        : {1'b0, 1'b1, k[1:0], k, ~k, k, 16'h1000 + 16'(i)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [28:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic go(input logic [2:0] n);
        start = 1'b1; len = n;
        step();
        start = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_bus", bus, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {res_cout, res}, 0);
        check("rst_opcnt", op_cnt, 0);
        step();
        reset = 1'b1;

        load(0, {1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 3'd3, 16'hcdef});
        go(0);
        check("len0_word", {wr, wr_addr, d_in}, {1'b1, 3'd3, 16'hcdef});
        check("len0_busy", {busy, done}, 2'b10);
        step();
        check("len0_done", {busy, done, wr}, 3'b010);
        step();
        check("len0_done_off", done, 0);
        check("len0_opcnt", op_cnt, 0);

        for (int i = 0; i < 8; i++) load(3'(i), pw(i));
        ret_a = 16'h0000; ret_c = 1'b1;
        go(7);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("run8_word%0d", k), bus, pw(k));
            step();
        end
        check("run8_done", {busy, done}, 2'b01);
        check("run8_bus", bus, 0);
        check("run8_res", {res_cout, res}, {1'b1, 16'h0000});
        check("run8_opcnt", op_cnt, 1);
        step();

        ret_a = 16'ha5a5; ret_c = 1'b0;
        go(7);
        repeat (8) step();
        check("cap_done", done, 1);
        check("cap_res", {res_cout, res}, {1'b0, 16'ha5a5});
        check("cap_opcnt", op_cnt, 2);
        step();

        go(7);
        step();
        step();
        check("abort_pre", bus, pw(2));
        abort = 1'b1;
        step();
        check("abort_bus", bus, 0);
        check("abort_done", {busy, done}, 2'b01);
        check("abort_opcnt", op_cnt, 2);
        abort = 1'b0;
        step();
        check("abort_after", {done, bus}, 0);

        abort = 1'b1;
        go(7);
        check("abort_start", {busy, bus}, 0);
        abort = 1'b0;
        step();
        check("abort_start_idle", busy, 0);

        go(7);
        ld_en = 1'b1; ld_addr = 3'd2; ld_data = 29'h1; start = 1'b1; len = 3'd0;
        step();
        ld_en = 1'b0;
        step();
        check("busy_ld_word2", bus, pw(2));
        start = 1'b0;
        repeat (5) step();
        check("busy_len_ignored", {busy, bus}, {1'b1, pw(7)});
        step();
        check("busy_run_done", done, 1);
        step();
        go(7);
        step();
        step();
        check("busy_ld_rerun", bus, pw(2));
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();

        loop = 1'b1;
        go(1);
        check("loop_w0", bus, pw(0));
        step();
        check("loop_w1", bus, pw(1));
        step();
`ifdef REG_ALU_SEQ_LOOP_EN
        check("loop_wrap0", {busy, bus}, {1'b1, pw(0)});
        step();
        check("loop_wrap1", bus, pw(1));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("loop_abort_done", {done, bus}, {1'b1, 29'h0});
`else
        check("noloop_done", {done, bus}, {1'b1, 29'h0});
`endif
        loop = 1'b0;
        step();

        go(7);
        step();
        #3 reset = 1'b0;
        #1;
        check("arst_bus", bus, 0);
        check("arst_flags", {busy, done}, 0);
        check("arst_res", {res_cout, res}, 0);
        check("arst_opcnt", op_cnt, 0);
        done_seen = 0;
        repeat (4) begin
            step();
            if (done) done_seen++;
        end
        reset = 1'b1;
        repeat (4) begin
            step();
            if (done) done_seen++;
        end
        check("arst_no_done", done_seen, 0);
        go(7);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("arst_mem%0d", k), {busy, bus}, {1'b1, 29'h0});
            step();
        end
        check("arst_run_done", done, 1);
        check("arst_run_opcnt", op_cnt, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_alu_seq.md
REG_ALU_SEQ -- requirements
Module: reg_alu_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; reset=0 forces reset state immediately.
REQ-003 SHALL have port: ld_en  input  1  write ld_data into program slot ld_addr.
REQ-004 SHALL have port: ld_addr  input  3  program slot index 0..7.
REQ-005 SHALL have port: ld_data  input  29  control word {sel, wr, op[1:0], rd_addr_a[2:0], rd_addr_b[2:0], wr_addr[2:0], d_in[15:0]}, bit 28 = sel.
REQ-006 SHALL have port: start  input  1  begin run at slot 0.
REQ-007 SHALL have port: len  input  3  last slot to issue, sampled with start.
REQ-008 SHALL have port: abort  input  1  terminate run.
REQ-009 SHALL have port: loop  input  1  wrap to slot 0 after slot len (see Configuration).
REQ-010 SHALL have ports: sel 1, wr 1, op 2, rd_addr_a 3, rd_addr_b 3, wr_addr 3, d_in 16; all outputs, registered, driving the register-file/ALU block.
REQ-011 SHALL have ports: d_out_a 16, d_out_b 16, cout 1; inputs returned by the register-file/ALU block.
REQ-012 SHALL have ports: busy 1, done 1, res 16, res_cout 1, op_cnt 4; all outputs, registered.

Function
REQ-013 SHALL hold an 8x29 program memory; ld_en write at edge when state is IDLE; ld_en while busy=1 SHALL be ignored.
REQ-014 SHALL implement FSM states IDLE, RUN, FIN.
REQ-015 IDLE: start=1 and abort=0 at edge -> RUN, ptr=0, last=len, bus = slot 0 word, busy=1.
REQ-016 RUN: each edge advances ptr by 1 and drives bus with slot ptr+1; at ptr=last, next state FIN and bus = all-zero word.
REQ-017 Bus SHALL show exactly one word per cycle; word k on bus in the (k+1)th cycle after the start edge.
REQ-018 At each RUN edge where current bus sel=1: res<=d_out_a, res_cout<=cout, op_cnt<=op_cnt+1 (mod 16).
REQ-019 FIN: done=1, busy=0 for exactly one cycle, then IDLE; done=0 at all other times.
REQ-020 Run of len=N SHALL produce done N+2 cycles after the start edge.
REQ-021 start while busy=1 SHALL be ignored; len change mid-run SHALL be ignored.
REQ-022 abort=1 at any RUN edge -> bus all-zero, FIN next (done pulses); abort and start on same IDLE edge -> abort wins, stay IDLE.
REQ-023 Bus SHALL be all-zero (wr=0, sel=0) in IDLE and FIN so the register file is never written outside a run.
REQ-024 len=0 SHALL issue slot 0 only.

Reset
REQ-025 reset=0 SHALL clear: state IDLE, ptr 0, all bus outputs 0, busy 0, done 0, res 0, res_cout 0, op_cnt 0, program memory all-zero.
REQ-026 reset mid-run SHALL abandon the run without a done pulse; first run after release SHALL behave as REQ-015.

Configuration
REQ-027 Macro REG_ALU_SEQ_LOOP_EN: defined -> at ptr=last with loop=1 and abort=0, next word is slot 0 and state stays RUN (abort is the only exit); undefined -> loop port ignored, run always ends per REQ-016.

Verification
REQ-028 Load slot0={0,1,xx->00,0,0,3,16'hcdef}, len=0, start -> one cycle wr=1 wr_addr=3 d_in=cdef, done 2 cycles after start, op_cnt=0.
REQ-029 Load 8 slots (slot5 sel=1 op=00 rd_a=1 rd_b=5; return d_out_a=16'h0000 cout=1 stimulus), len=7 -> 8 consecutive words in slot order, res=0000, res_cout=1, op_cnt=1, done at cycle 9.
REQ-030 len=7, abort asserted at 3rd RUN edge -> bus zero next cycle, done=1 once, slots 3..7 never issued.
REQ-031 ld_en with ld_addr=2 ld_data=29'h1 while busy=1 -> slot 2 unchanged on next run; start while busy -> no restart.
REQ-032 reset=0 asynchronously mid-run (between edges) -> all outputs 0 immediately, no done pulse, memory read back all-zero.
REQ-033 With REG_ALU_SEQ_LOOP_EN, len=1, loop=1 -> pattern slot0,slot1,slot0,slot1... until abort, then done; without macro same stimulus -> done after 2 words.
